reg_bank_8x16: RTL

- Bank of eight 16-bit general-purpose registers for the simple processor datapath.
- Sits directly upstream of the 16-bit 8-to-1 operand multiplexer. Outputs Q0..Q7 drive that mux's X0..X7 inputs.
- Provides one synchronous write port and two combinational read ports (A/B operands).
- Has a sequenced clear-all operation: a small FSM sweeps the bank one register per cycle.

---
 rtl/reg_bank_8x16_if.sv | 33 +++
 rtl/reg_bank_8x16.sv | 90 +++++++++
 2 files changed

// File: rtl/reg_bank_8x16_if.sv
// Register bank access bus: one write port, a clear-all request and two read ports.
// Ports:
//   wr_en, wr_addr, wr_data   write request, destination index, data
//   wr_ack                    one-cycle pulse after a committed write
//   clr_req, clr_busy         clear-all request and sweep-in-progress flag
//   rd_addr_a/b, rd_data_a/b  combinational read ports A and B
// master: requester side; slave: register bank side.
interface reg_bank_8x16_if #(
  parameter int unsigned WIDTH = 16
) ();
  localparam int unsigned AW = 3;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ack;
  logic             clr_req;
  logic             clr_busy;
  logic [AW-1:0]    rd_addr_a;
  logic [WIDTH-1:0] rd_data_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_b;

  modport master (
    output wr_en, wr_addr, wr_data, clr_req, rd_addr_a, rd_addr_b,
    input  wr_ack, clr_busy, rd_data_a, rd_data_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clr_req, rd_addr_a, rd_addr_b,
    output wr_ack, clr_busy, rd_data_a, rd_data_b
  );
endinterface

// File: rtl/reg_bank_8x16.sv
// Eight WIDTH-bit general-purpose registers feeding the 8-to-1 operand mux.
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   bus      slave side of reg_bank_8x16_if (write, clear-all, two read ports)
//   q0..q7   direct register outputs to mux inputs X0..X7
// A clear-all request starts a sweep that writes CLR_VAL to one register per
// cycle; writes arriving during the sweep are dropped, not queued.
module reg_bank_8x16 #(
  parameter int unsigned         WIDTH   = 16,
  parameter logic [WIDTH-1:0]    CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  reg_bank_8x16_if.slave   bus,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7
);
  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] regs [NREG];

  // State, register array, sweep counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
      state        <= IDLE;
      cnt          <= '0;
      bus.clr_busy <= 1'b0;
      bus.wr_ack   <= 1'b0;
    end else begin
      bus.wr_ack <= 1'b0;
      case (state)
        IDLE: begin
          // A write coinciding with a clear request still commits; the sweep
          // overwrites it later.
          if (bus.wr_en) begin
            regs[bus.wr_addr] <= bus.wr_data;
            bus.wr_ack        <= 1'b1;
          end
          if (bus.clr_req) begin
            state        <= CLEAR;
            cnt          <= '0;
            bus.clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          regs[cnt] <= CLR_VAL;
          cnt       <= AW'(cnt + AW'(1));
          if (cnt == AW'(NREG - 1)) begin
            state        <= IDLE;
            bus.clr_busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read ports have no write bypass: a same-cycle write returns the old value.
  assign bus.rd_data_a = regs[bus.rd_addr_a];
  assign bus.rd_data_b = regs[bus.rd_addr_b];

  assign q0 = regs[0];
  assign q1 = regs[1];
  assign q2 = regs[2];
  assign q3 = regs[3];
  assign q4 = regs[4];
  assign q5 = regs[5];
  assign q6 = regs[6];
  assign q7 = regs[7];
endmodule
